instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage of the KGP-RISC core, directly upstream of the control decoder.
//  Holds the PC and issues req/ack fetches to instruction memory.
//  Registers each returned 32-bit word and presents it to decode under a valid/ready handshake.
//  Applies branch redirects from the branch unit (b, br, bltz/bz/bnz/bcy/bncy, bl) and squashes wrong-path fetches.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; word aligned.
//  CNT_W      16             Width of the retired-instruction counter.
// PORTS
//  clk            in   1      Clock; all state updates on the rising edge.
//  reset          in   1      Synchronous reset, active high.
//  imem_req       out  1      Fetch request; held high until imem_ack.
//  imem_addr      out  32     Byte address of the fetch; equals pc_out whenever imem_req=1.
//  imem_ack       in   1      One-cycle pulse, earliest in the cycle imem_req first rises; completes the request.
//  imem_rdata     in   32     Instruction word; valid only in the imem_ack cycle.
//  instr          out  32     Registered instruction presented to decode.
//  opcode         out  6      instr[31:26] when instr_valid=1, else 6'b111111 (decodes to all-zero controls).
//  instr_valid    out  1      instr/opcode/pc_out hold a live instruction.
//  instr_ready    in   1      Decode/execute consumes the instruction this cycle.
//  branch_taken   in   1      Redirect request; single-cycle pulse.
//  branch_target  in   32     Redirect address; sampled with branch_taken; bits [1:0] ignored (forced 0).
//  pc_out         out  32     Address of the current/outstanding instruction.
//  pc_plus4       out  32     pc_out + 4, modulo 2^32; link value for bl.
//  retired_count  out  CNT_W  Number of consumed instructions; wraps.
// BEHAVIOUR
//  Reset (reset=1 at an edge) sets state=IDLE, pc=RESET_PC, imem_req=0, instr=0, instr_valid=0,
//   retired_count=0, redirect_pend=0, pend_target=0. Also gives opcode=6'h3F and pc_plus4=RESET_PC+4.
//  Reset overrides everything, including a mid-flight request; a late imem_ack after reset is ignored (state IDLE).
//  FSM states: IDLE, FETCH, HOLD.
//  IDLE: imem_req=0 -> FETCH next cycle unconditionally. First imem_req is the 2nd cycle after reset falls.
//  FETCH: imem_req=1, imem_addr=pc.
//   - imem_ack and no redirect_pend and no branch_taken: instr<=imem_rdata, instr_valid<=1 -> HOLD.
//   - imem_ack and (redirect_pend or branch_taken): data discarded.
//     pc<=branch_target if branch_taken this cycle, else pend_target; redirect_pend<=0.
//     Stay in FETCH; the new request appears the next cycle (imem_req stays high across the boundary).
//   - no ack, branch_taken: redirect_pend<=1, pend_target<=branch_target; imem_addr unchanged until ack.
//   - Later branch_taken while pending overwrites pend_target (last redirect wins).
//  HOLD: instr_valid=1; instr/pc_out stable until leaving HOLD.
//   - branch_taken: pc<=branch_target -> FETCH, instr_valid<=0.
//     If instr_ready is also 1, the instruction counts as consumed.
//   - instr_ready, no branch_taken: pc<=pc+4 -> FETCH, instr_valid<=0.
//   - neither: remain in HOLD.
//  Throughput: with 0-wait memory (ack in the req cycle) and ready always 1, one instruction every 2 cycles.
//  retired_count increments by 1 on every cycle with instr_valid & instr_ready; wraps 2^CNT_W-1 -> 0.
//  PC arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000. pc[1:0] is always 0.
//  imem_ack outside FETCH is ignored. instr_ready outside HOLD is ignored. branch_taken in IDLE is ignored.
// TESTING
//  T1 RESET_PC=0, ack in req cycle, ready=1.
//     -> reset state as listed; addrs 0,4,8; instr_valid every 2nd cycle; retired_count=3 after 3 handshakes.
//  T2 ack 3 cycles after req, ready=0 for 4 cycles in HOLD.
//     -> imem_req high 4 cycles; instr/pc_out stable; no PC advance; retired_count unchanged until ready=1.
//  T3 In HOLD at pc=0x10, branch_taken=1, target=0x40, ready=1.
//     -> retired_count+1; next imem_addr=0x40; no fetch at 0x14.
//  T4 In FETCH at 0x20, branch_taken (target 0x80) 1 cycle before ack with rdata=0xDEADBEEF.
//     -> word discarded; instr_valid stays 0; next imem_addr=0x80.
//  T5 pc=0xFFFF_FFFC, ready=1 -> next imem_addr=0x0; pc_plus4=0x0 while at 0xFFFF_FFFC.
//  T6 reset asserted in FETCH with ack arriving the same cycle -> IDLE, instr_valid=0, opcode=6'h3F;
//     refetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/ack fetches to instruction memory,
// holds each fetched word for decode and applies branch redirects, squashing wrong-path data.
module instr_fetch_unit #(
    parameter logic [31:0]  RESET_PC = 32'h0000_0000,
    parameter int unsigned  CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic [31:0]       pc_out,
    output logic [31:0]       pc_plus4,
    output logic [CNT_W-1:0]  retired_count
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 6;
    localparam logic [OP_W-1:0] OP_NONE = 6'h3F;
    localparam logic [XLEN-1:0] WORD    = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t          state;
    logic            redirect_pend;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] branch_pc;
    logic [XLEN-1:0] squash_pc;
    logic [XLEN-1:0] hold_next_pc;
    logic            consume;

    // Redirect targets are always word aligned.
    assign branch_pc    = branch_target & ~32'h0000_0003;
    assign squash_pc    = branch_taken ? branch_pc : pend_target;
    assign hold_next_pc = branch_taken ? branch_pc : pc_plus4;
    assign consume      = instr_valid & instr_ready;
    assign imem_addr    = pc_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pc_out        <= RESET_PC;
            pc_plus4      <= RESET_PC + WORD;
            imem_req      <= 1'b0;
            instr         <= '0;
            opcode        <= OP_NONE;
            instr_valid   <= 1'b0;
            retired_count <= '0;
            redirect_pend <= 1'b0;
            pend_target   <= '0;
        end else begin
            if (consume) begin
                retired_count <= retired_count + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end

                S_FETCH: begin
                    if (imem_ack) begin
                        if (redirect_pend || branch_taken) begin
                            // Wrong-path word: drop it and reissue at the redirect target.
                            pc_out        <= squash_pc;
                            pc_plus4      <= squash_pc + WORD;
                            redirect_pend <= 1'b0;
                        end else begin
                            instr       <= imem_rdata;
                            opcode      <= imem_rdata[XLEN-1:XLEN-OP_W];
                            instr_valid <= 1'b1;
                            imem_req    <= 1'b0;
                            state       <= S_HOLD;
                        end
                    end else if (branch_taken) begin
                        // Address must stay put until the outstanding request completes.
                        redirect_pend <= 1'b1;
                        pend_target   <= branch_pc;
                    end
                end

                S_HOLD: begin
                    if (branch_taken || instr_ready) begin
                        pc_out      <= hold_next_pc;
                        pc_plus4    <= hold_next_pc + WORD;
                        instr_valid <= 1'b0;
                        opcode      <= OP_NONE;
                        imem_req    <= 1'b1;
                        state       <= S_FETCH;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: a table-driven memory/decode model checks every
// fetch address, every delivered instruction, redirects, PC wrap and reset behaviour.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned CW     = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [31:0]   instr;
    logic [5:0]    opcode;
    logic          instr_valid;
    logic          instr_ready;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic [31:0]   pc_out;
    logic [31:0]   pc_plus4;
    logic [CW-1:0] retired_count;

    instr_fetch_unit #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    // One planned memory request: wait cycles, branch pulses per wait cycle, optional reset at ack.
    typedef struct {
        logic [31:0] addr;
        int          lat;
        logic [3:0]  br_mask;
        logic [31:0] tgt;
        bit          use_data;
        logic [31:0] data;
        bit          rst;
    } fetch_t;

    // One planned delivery to decode: cycles of back-pressure, optional branch at consume.
    typedef struct {
        logic [31:0] pc;
        int          hold;
        bit          br;
        logic [31:0] tgt;
    } dlv_t;

    fetch_t      fq[$];
    dlv_t        dq[$];
    int          hs_cyc[$];
    fetch_t      cur;
    dlv_t        cur_d;
    bit          busy = 1'b0;
    bit          dbusy = 1'b0;
    int          wait_k = 0;
    int          hold_k = 0;
    int          cyc = 0;
    logic [CW-1:0] model_cnt = '0;
    bit          rst_cmd = 1'b1;
    bit          prev_rst = 1'b1;
    bit          prev2_rst = 1'b1;
    int          n_chk = 0;
    int          n_err = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_f(input logic [31:0] addr, input int lat, input logic [3:0] mask,
                          input logic [31:0] tgt, input bit use_data, input logic [31:0] data,
                          input bit rst);
        fetch_t f;
        f = '{addr, lat, mask, tgt, use_data, data, rst};
        fq.push_back(f);
    endtask

    task automatic push_d(input logic [31:0] pc, input int hold, input bit br, input logic [31:0] tgt);
        dlv_t d;
        d = '{pc, hold, br, tgt};
        dq.push_back(d);
    endtask

    // Memory and decode model: all DUT inputs are driven here, on the falling edge.
    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_rst) begin
                check("rst_req",     32'(imem_req),      32'd0);
                check("rst_valid",   32'(instr_valid),   32'd0);
                check("rst_opcode",  32'(opcode),        32'h3F);
                check("rst_pc",      pc_out,             RST_PC);
                check("rst_addr",    imem_addr,          RST_PC);
                check("rst_pc4",     pc_plus4,           RST_PC + 32'd4);
                check("rst_instr",   instr,              32'd0);
                check("rst_retired", 32'(retired_count), 32'd0);
            end else if (prev2_rst) begin
                check("first_req",  32'(imem_req), 32'd1);
                check("first_addr", imem_addr,      RST_PC);
            end
            prev2_rst = prev_rst;

            imem_ack = 1'b0; branch_taken = 1'b0; branch_target = $urandom;
            imem_rdata = $urandom; instr_ready = 1'b1; reset = rst_cmd;
            if (rst_cmd) begin
                busy = 1'b0; dbusy = 1'b0; model_cnt = '0;
            end

            if (busy && !imem_req) begin
                check("req_held", 32'(imem_req), 32'd1);
                busy = 1'b0;
            end else if (imem_req && !rst_cmd) begin
                if (!busy && fq.size() > 0) begin
                    cur = fq.pop_front();
                    busy = 1'b1;
                    wait_k = 0;
                    check("fetch_addr", imem_addr, cur.addr);
                end else if (busy) begin
                    check("addr_stable", imem_addr, cur.addr);
                end
                if (busy) begin
                    if (cur.br_mask[2'(wait_k)]) begin
                        branch_taken  = 1'b1;
                        branch_target = cur.tgt + 32'(wait_k) * 32'h100;
                    end
                    if (wait_k == cur.lat) begin
                        imem_ack   = 1'b1;
                        imem_rdata = cur.use_data ? cur.data : word_at(cur.addr);
                        busy = 1'b0;
                        if (cur.rst) begin
                            reset = 1'b1; dbusy = 1'b0; model_cnt = '0;
                        end
                    end else begin
                        wait_k++;
                    end
                end
            end

            if (instr_valid && !reset) begin
                if (!dbusy) begin
                    if (dq.size() == 0) begin
                        check("dlv_unexpected", 32'(instr_valid), 32'd0);
                        check("retired", 32'(retired_count), 32'(model_cnt));
                        model_cnt++;
                    end else begin
                        cur_d = dq.pop_front();
                        dbusy = 1'b1;
                        hold_k = 0;
                        check("dlv_pc",     pc_out,      cur_d.pc);
                        check("dlv_instr",  instr,       word_at(cur_d.pc));
                        check("dlv_opcode", 32'(opcode), word_at(cur_d.pc) >> 26);
                        check("dlv_pc4",    pc_plus4,    cur_d.pc + 32'd4);
                    end
                end else begin
                    check("hold_instr", instr,          word_at(cur_d.pc));
                    check("hold_pc",    pc_out,         cur_d.pc);
                    check("hold_req",   32'(imem_req),  32'd0);
                end
                if (dbusy) begin
                    if (hold_k < cur_d.hold) begin
                        instr_ready = 1'b0;
                        hold_k++;
                    end else begin
                        if (cur_d.br) begin
                            branch_taken  = 1'b1;
                            branch_target = cur_d.tgt;
                        end
                        check("retired", 32'(retired_count), 32'(model_cnt));
                        model_cnt++;
                        hs_cyc.push_back(cyc);
                        dbusy = 1'b0;
                    end
                end
            end
            prev_rst = reset;
        end
    end

    initial begin
        bit done;
        repeat (4) @(negedge clk);
        #1;
        // Sequential run, back-pressure, HOLD branch, squashed fetch, PC wrap,
        // branch-with-ack, last-redirect-wins, reset during an acked fetch.
        push_f(32'h0000_0000, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0);
        push_f(32'h0000_0004, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0);
        push_f(32'h0000_0008, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0);
        push_f(32'h0000_000C, 3, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0);
        push_f(32'h0000_0010, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0);
        push_f(32'h0000_0040, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0);
        push_f(32'h0000_0020, 1, 4'b0001, 32'h80, 1'b1, 32'hDEAD_BEEF, 1'b0);
        push_f(32'h0000_0080, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0);
        push_f(32'hFFFF_FFFC, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0);
        push_f(32'h0000_0000, 0, 4'b0001, 32'h100, 1'b0, 32'h0, 1'b0);
        push_f(32'h0000_0100, 2, 4'b0011, 32'h200, 1'b0, 32'h0, 1'b0);
        push_f(32'h0000_0300, 0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0);
        push_f(32'h0000_0304, 1, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1);
        push_f(RST_PC,        0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0);

        push_d(32'h0000_0000, 0, 1'b0, 32'h0);
        push_d(32'h0000_0004, 0, 1'b0, 32'h0);
        push_d(32'h0000_0008, 0, 1'b0, 32'h0);
        push_d(32'h0000_000C, 4, 1'b0, 32'h0);
        push_d(32'h0000_0010, 0, 1'b1, 32'h40);
        push_d(32'h0000_0040, 0, 1'b1, 32'h20);
        push_d(32'h0000_0080, 0, 1'b1, 32'hFFFF_FFFF);
        push_d(32'hFFFF_FFFC, 0, 1'b0, 32'h0);
        push_d(32'h0000_0300, 0, 1'b0, 32'h0);
        push_d(RST_PC,        0, 1'b0, 32'h0);
        rst_cmd = 1'b0;

        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            #1;
            done = (fq.size() == 0) && (dq.size() == 0) && !busy && !dbusy;
        end
        check("drain_timeout", 32'(done), 32'd1);

        repeat (3) @(negedge clk);
        #1;
        check("final_retired", 32'(retired_count), 32'd1);
        check("final_valid",   32'(instr_valid),   32'd0);
        check("stall_req",     32'(imem_req),      32'd1);
        check("stall_addr",    imem_addr,          RST_PC + 32'd4);
        if (hs_cyc.size() >= 3) begin
            check("t1_gap01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
            check("t1_gap12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
        end else begin
            check("t1_hs_count", 32'(hs_cyc.size()), 32'd3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
